// File: rtl/mem_resp.sv
// Word-addressed SRAM responder with programmable access latency and byte write strobes.
// Optional out-of-range address error reporting is enabled by defining MEM_RESP_ERR_EN.
module mem_resp #(
    parameter int unsigned ISA_WIDTH  = 32,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ISA_WIDTH-1:0]   mem_addr,
    input  logic [ISA_WIDTH-1:0]   mem_w,
    input  logic [ISA_WIDTH/8-1:0] mem_wmask,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    output logic                   mem_req_ready,
    output logic [ISA_WIDTH-1:0]   mem_r,
    output logic                   mem_resp_valid,
    output logic                   mem_err
);

    localparam int unsigned NB    = ISA_WIDTH / 8;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_accept;
    logic                   w_fire;

    logic [DEPTH_LOG2-1:0]  r_idx;
    logic [ISA_WIDTH-1:0]   r_wdata;
    logic [NB-1:0]          r_wmask;
    logic                   r_wr;
    logic                   r_oor;

    logic [DEPTH_LOG2-1:0]  w_in_idx;
    logic                   w_in_oor;
    logic [DEPTH_LOG2-1:0]  w_acc_idx;
    logic [ISA_WIDTH-1:0]   w_acc_wdata;
    logic [NB-1:0]          w_acc_wmask;
    logic                   w_acc_wr;
    logic                   w_acc_oor;
    logic                   w_unused_addr;

    logic [ISA_WIDTH-1:0]   r_mem [0:DEPTH-1];
    logic [ISA_WIDTH-1:0]   r_rdata;
    logic                   r_valid;
    logic                   r_err;

    assign w_in_idx      = mem_addr[DEPTH_LOG2+1:2];
    assign w_unused_addr = ^{mem_addr[1:0], mem_addr[ISA_WIDTH-1:DEPTH_LOG2+2]};
`ifdef MEM_RESP_ERR_EN
    assign w_in_oor      = |mem_addr[ISA_WIDTH-1:DEPTH_LOG2+2];
`else
    assign w_in_oor      = 1'b0;
`endif

    assign mem_req_ready = (r_state == IDLE);
    assign w_accept      = (r_state == IDLE) && (mem_r_en || mem_w_en);

    // With LATENCY == 1 the access happens on the accept edge, so take the live request.
    assign w_acc_idx   = (r_state == IDLE) ? w_in_idx  : r_idx;
    assign w_acc_wdata = (r_state == IDLE) ? mem_w     : r_wdata;
    assign w_acc_wmask = (r_state == IDLE) ? mem_wmask : r_wmask;
    assign w_acc_wr    = (r_state == IDLE) ? mem_w_en  : r_wr;
    assign w_acc_oor   = (r_state == IDLE) ? w_in_oor  : r_oor;

    // Next-state and latency counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                        w_fire      = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = RESP;
                    w_fire      = 1'b1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_fire;
            r_err   <= w_fire && w_acc_oor;
            if (w_fire) begin
                r_rdata <= w_acc_oor ? '0 : r_mem[w_acc_idx];
            end
        end
    end

    // Request capture; write wins when both enables are high.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= w_in_idx;
            r_wdata <= mem_w;
            r_wmask <= mem_wmask;
            r_wr    <= mem_w_en;
            r_oor   <= w_in_oor;
        end
    end

    // Array update; reset on the completing edge discards the write.
    always_ff @(posedge clk) begin
        if (!rst && w_fire && w_acc_wr && !w_acc_oor) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (w_acc_wmask[b]) begin
                    r_mem[w_acc_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign mem_r          = r_rdata;
    assign mem_resp_valid = r_valid;
`ifdef MEM_RESP_ERR_EN
    assign mem_err        = r_err;
`else
    assign mem_err        = 1'b0;
`endif

endmodule
